vx_stream_scatter: RTL
======================

// Module: vx_stream_scatter
// PURPOSE
//  Consumer of a packed multi-lane stream (valid, lane mask, per-lane data, shared tag).
//  Splits each packet into NUM_REQS independent per-lane valid/ready streams, each lane carrying data and tag.
//  Lanes drain in any order; the packet retires only after every masked lane has been accepted.
//  Sits directly downstream of the stream packer; feeds per-bank/per-port request queues.
// PARAMETERS
//  NUM_REQS    4   number of output lanes (>=1)
//  DATA_WIDTH  32  per-lane data width
//  TAG_WIDTH   8   shared packet tag width, replicated to every lane
//  OUT_BUF     0   0: combinational lane outputs; 1: per-lane 2-entry skid buffer (registered outputs)
// PORTS
//  clk        in   1                     clock, rising edge
//  reset_n    in   1                     asynchronous, active-low reset
//  valid_in   in   1                     packet valid
//  mask_in    in   NUM_REQS              lanes present in packet
//  data_in    in   NUM_REQS*DATA_WIDTH   per-lane data
//  tag_in     in   TAG_WIDTH             packet tag
//  ready_in   out  1                     packet retired this cycle
//  valid_out  out  NUM_REQS              per-lane valid
//  data_out   out  NUM_REQS*DATA_WIDTH   per-lane data
//  tag_out    out  NUM_REQS*TAG_WIDTH    per-lane tag (copy of tag_in)
//  ready_out  in   NUM_REQS              per-lane ready
//  busy       out  1                     packet partially drained (sent_mask != 0)
// BEHAVIOUR
//  - State: sent_mask[NUM_REQS] = lanes of the current packet already accepted. Reset value 0.
//  - Lane sink ready lr[i]: ready_out[i] when OUT_BUF=0; skid-buffer input ready when OUT_BUF=1.
//  - pending = valid_in ? (mask_in & ~sent_mask) : 0.
//  - Lane sink valid lv[i] = pending[i]; fire[i] = lv[i] & lr[i].
//  - ready_in = valid_in & ((pending & ~fire) == 0); combinational, same cycle.
//  - sent_mask next: ready_in -> 0; else valid_in -> sent_mask | fire; else hold.
//  - Never re-issues a lane already in sent_mask. Lanes are independent; no inter-lane ordering within a packet.
//  - valid_in with mask_in == 0: ready_in = 1 that cycle; no lane output; packet dropped.
//  - OUT_BUF=0: zero latency; valid/data/tag_out are combinational from the inputs.
//  - OUT_BUF=1: 1-cycle latency, full throughput per lane.
//    - Skid buffer accepts while holding <2 entries.
//    - Outputs driven only from registers.
//  - Throughput: one packet per cycle when all masked lanes are ready.
//  - Upstream protocol: while valid_in & !ready_in, mask_in, data_in and tag_in are held stable.
//    Simulation assertion flags any violation.
//  - Reset (reset_n low, any time, asynchronous):
//    - sent_mask and all skid-buffer state clear immediately.
//    - valid_out = 0, busy = 0. ready_in is forced 0 while reset_n is low.
//    - A packet interrupted by reset is fully re-issued if presented after release.
//  - NUM_REQS == 1: sent_mask unused; valid_out = valid_in & mask_in.
//    - ready_in = lr | ~mask_in.
// TESTING
//  1. NUM_REQS=4, OUT_BUF=0, mask_in=4'b1011, ready_out=4'b1111 -> valid_out=1011 and ready_in=1 in the same cycle; busy=0.
//  2. mask_in=1111, ready_out=0001 in cycle 0, then 1111:
//     - cycle 0: ready_in=0, sent_mask=0001, busy=1.
//     - cycle 1: valid_out=1110, ready_in=1.
//     - cycle 2: busy=0.
//  3. valid_in=1, mask_in=0000 -> ready_in=1, valid_out=0000 for that cycle.
//  4. 16 back-to-back packets, tags 0..15, all lanes ready -> 16 retirements in 16 cycles.
//     Each lane sees tags in order with matching data.
//  5. OUT_BUF=1, lane 2 ready_out held 0 for 3 cycles mid-stream:
//     - lane outputs lag by exactly 1 cycle.
//     - no lost or duplicated beat; other lanes are stalled only via ready_in.
//  6. reset_n pulled low after lane 0 of a 4-lane packet is accepted:
//     - valid_out=0 and busy=0 immediately.
//     - after release, the same packet is presented again -> all 4 lanes are re-issued.

Source files
------------

// File: rtl/vx_stream_scatter.sv
`default_nettype none
// ============================================================================
// Module   : vx_stream_scatter
// Purpose  : Splits a packed multi-lane packet (valid, lane mask, per-lane
//            data, shared tag) into NUM_REQS independent per-lane valid/ready
//            streams. Lanes drain in any order; the packet retires (ready_in)
//            only once every masked lane has been accepted.
// Ports    : clk, reset_n (async, active-low)
//            valid_in/mask_in/data_in/tag_in -> packet input, ready_in = retire
//            valid_out/data_out/tag_out/ready_out -> per-lane output streams
//            busy -> packet partially drained
// Revision : 1.0  initial release
// ============================================================================
module vx_stream_scatter #(
  parameter int NUM_REQS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 8,
  parameter int OUT_BUF    = 0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           valid_in,
  input  logic [NUM_REQS-1:0]            mask_in,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] data_in,
  input  logic [TAG_WIDTH-1:0]           tag_in,
  output logic                           ready_in,
  output logic [NUM_REQS-1:0]            valid_out,
  output logic [NUM_REQS*DATA_WIDTH-1:0] data_out,
  output logic [NUM_REQS*TAG_WIDTH-1:0]  tag_out,
  input  logic [NUM_REQS-1:0]            ready_out,
  output logic                           busy
);

  localparam int c_BEAT_W = DATA_WIDTH + TAG_WIDTH;

  logic [NUM_REQS-1:0] r_sent_mask;
  logic [NUM_REQS-1:0] w_pending;
  logic [NUM_REQS-1:0] w_lr;
  logic [NUM_REQS-1:0] w_fire;

  // Lanes still owed for the current packet; gated by reset_n so nothing is
  // offered while the block is held in reset.
  assign w_pending = (reset_n && valid_in) ? (mask_in & ~r_sent_mask) : '0;
  assign w_fire    = w_pending & w_lr;

  // Retire when no owed lane is left unaccepted this cycle (covers mask == 0).
  assign ready_in  = reset_n & valid_in & ((w_pending & ~w_fire) == '0);
  assign busy      = |r_sent_mask;

  generate
    if (NUM_REQS > 1) begin : g_multi
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_sent_mask <= '0;
        end else if (ready_in) begin
          r_sent_mask <= '0;
        end else if (valid_in) begin
          r_sent_mask <= r_sent_mask | w_fire;
        end
      end
    end else begin : g_single
      // A single lane either fires and retires the packet or stalls, so
      // there is never any partial progress to remember.
      assign r_sent_mask = '0;
    end
  endgenerate

  generate
    for (genvar i = 0; i < NUM_REQS; i++) begin : g_lane
      if (OUT_BUF == 0) begin : g_comb
        assign w_lr[i]                                = ready_out[i];
        assign valid_out[i]                           = w_pending[i];
        assign data_out[i*DATA_WIDTH +: DATA_WIDTH]   = data_in[i*DATA_WIDTH +: DATA_WIDTH];
        assign tag_out[i*TAG_WIDTH +: TAG_WIDTH]      = tag_in;
      end else begin : g_skid
        // Two-entry skid buffer: head drives the outputs, tail catches the
        // beat that arrives in the cycle the head stalls.
        logic                r_head_v;
        logic                r_tail_v;
        logic [c_BEAT_W-1:0] r_head;
        logic [c_BEAT_W-1:0] r_tail;
        logic [c_BEAT_W-1:0] w_beat;
        logic                w_push;
        logic                w_pop;

        assign w_beat  = {tag_in, data_in[i*DATA_WIDTH +: DATA_WIDTH]};
        assign w_push  = w_fire[i];
        assign w_pop   = r_head_v & ready_out[i];
        assign w_lr[i] = ~r_tail_v;

        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            r_head_v <= 1'b0;
            r_tail_v <= 1'b0;
            r_head   <= '0;
            r_tail   <= '0;
          end else if (!r_head_v) begin
            if (w_push) begin
              r_head   <= w_beat;
              r_head_v <= 1'b1;
            end
          end else if (!r_tail_v) begin
            if (w_push && w_pop) begin
              r_head <= w_beat;
            end else if (w_push) begin
              r_tail   <= w_beat;
              r_tail_v <= 1'b1;
            end else if (w_pop) begin
              r_head_v <= 1'b0;
            end
          end else if (w_pop) begin
            // Full: no push is possible, so only the tail advances.
            r_head   <= r_tail;
            r_tail_v <= 1'b0;
          end
        end

        assign valid_out[i]                         = r_head_v;
        assign data_out[i*DATA_WIDTH +: DATA_WIDTH] = r_head[DATA_WIDTH-1:0];
        assign tag_out[i*TAG_WIDTH +: TAG_WIDTH]    = r_head[c_BEAT_W-1:DATA_WIDTH];
      end
    end
  endgenerate

`ifndef SYNTHESIS
  // Upstream must hold the packet contents while it waits for retirement.
  a_hold_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (valid_in && !ready_in) |=> ($stable(mask_in) && $stable(data_in) && $stable(tag_in)));
`endif

endmodule
`default_nettype wire
